// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential RISC-V execute-stage ALU (alu_seq).
//   - 4-bit opcode encodings (ALU_AND .. ALU_MUL)
//   - FSM state encoding used by alu_seq (IDLE, BUSY, DONE)
// Optional feature macro: ALU_MUL_EN (consumed by alu_seq, not by this file).
// ---------------------------------------------------------------------------
package alu_pkg;

  // Opcode encodings on the 'control' input
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Sequencer states: IDLE waits for work, BUSY runs the multiplier,
  // DONE presents a result on the output channel.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// A 'start' pulse captures the operands; the following WIDTH cycles each
// consume one multiplier bit, LSB first. 'done' pulses for one cycle after
// the last iteration, while product_lo holds the finished product.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (aborts any operation)
//   start      in   load a/b and begin a multiplication
//   a, b       in   WIDTH-bit multiplicand / multiplier
//   busy       out  iterations in progress
//   done       out  one-cycle pulse: product_lo is valid
//   product_lo out  low WIDTH bits of the product
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One shift-add step per cycle: add the shifted multiplicand when the
  // current multiplier LSB is set, then shift both. Bits shifted past
  // WIDTH only affect the discarded upper half of the product.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
      if (count_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product_lo = acc_q;

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered RISC-V execute-stage ALU with valid/ready input and output
// channels. Single-cycle ops return one cycle after accept; MUL (when the
// ALU_MUL_EN macro is defined) runs on alu_mul_iter and returns WIDTH+1
// cycles after accept. Without ALU_MUL_EN the MUL opcode is illegal.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   operation presented
//   in_ready   out  operation can be accepted this cycle
//   number1    in   operand A
//   number2    in   operand B (low SHW bits are the shift amount)
//   control    in   4-bit opcode
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
//   result     out  registered result
//   zero       out  result == 0
//   illegal    out  opcode not supported
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             op_illegal;
  logic             op_is_mul;
  logic             accept;
  logic             take;
  logic             engine_idle;

  assign shamt  = number2[SHW-1:0];
  assign accept = in_valid & in_ready;

`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start   = take & op_is_mul;
  assign engine_idle = ~mul_busy;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .a         (number1),
    .b         (number2),
    .busy      (mul_busy),
    .done      (mul_done),
    .product_lo(mul_product)
  );
`else
  assign engine_idle = 1'b1;
`endif

  // Combinational datapath for the single-cycle ops. Illegal opcodes give
  // a zero result so 'zero' naturally reads 1 for them.
  always_comb begin
    alu_res    = '0;
    op_illegal = 1'b0;
    op_is_mul  = 1'b0;
    case (control)
      ALU_AND: alu_res = number1 & number2;
      ALU_OR:  alu_res = number1 | number2;
      ALU_ADD: alu_res = number1 + number2;
      ALU_SUB: alu_res = number1 - number2;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(number1) < $signed(number2))};
      ALU_NOR: alu_res = ~(number1 | number2);
      ALU_SLL: alu_res = number1 << shamt;
      ALU_SRL: alu_res = number1 >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(number1) >>> shamt);
`ifdef ALU_MUL_EN
      ALU_MUL: op_is_mul = 1'b1;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  // Next-state logic. 'take' marks an accepted op in IDLE, or in DONE when
  // the current result is consumed in the same cycle (back-to-back issue).
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    take      = 1'b0;
    case (state_q)
      IDLE: begin
        take = accept;
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          state_d   = DONE;
          result_d  = mul_product;
          zero_d    = (mul_product == '0);
          illegal_d = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          take = accept;
          if (!accept) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take) begin
      if (op_is_mul) begin
        state_d = BUSY;
      end else begin
        state_d   = DONE;
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = op_illegal;
      end
    end
  end

  // Output and state registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // in_ready is held low while reset is asserted; the multiplier interlock
  // is redundant with the state check but keeps issue safe if they diverge.
  assign in_ready  = ~reset & engine_idle &
                     ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq at WIDTH=64. Inputs change on the
// falling edge and outputs are sampled on the falling edge. MUL expectations
// follow the ALU_MUL_EN macro.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] number1;
  logic [63:0] number2;
  logic [3:0]  control;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp;
  int n_err;

  alu_seq #(.WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .number1  (number1),
    .number2  (number2),
    .control  (control),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one op for exactly one rising edge, returning on the next
  // falling edge (the accepting edge has then passed).
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    control  = op;
    number1  = a;
    number2  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Let any pending result drain so the DUT is IDLE.
  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    control = 4'b0000; number1 = '0; number2 = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 64'd0 || zero !== 1'b0 || illegal !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got in_ready=%b out_valid=%b result=%0h zero=%b illegal=%b, expected all 0",
               in_ready, out_valid, result, zero, illegal);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_sub_add();
    drain();
    issue(4'b0110, 64'd30, 64'd20);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd10 || zero !== 1'b0 || illegal !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL sub_30_20: got valid=%b result=%0d zero=%b illegal=%b, expected 1/10/0/0",
               out_valid, result, zero, illegal);
    end
    issue(4'b0010, 64'd20, 64'd30);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd50 || zero !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL add_20_30: got valid=%b result=%0d zero=%b, expected 1/50/0", out_valid, result, zero);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    control = 4'b0010; number1 = 64'd5; number2 = 64'd5; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd10 || zero !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_first: got valid=%b result=%0d zero=%b in_ready=%b, expected 1/10/0/1",
               out_valid, result, zero, in_ready);
    end
    control = 4'b0110; number1 = 64'd7; number2 = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd0 || zero !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_second: got valid=%b result=%0d zero=%b, expected 1/0/1", out_valid, result, zero);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_drain: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  op  [7];
    logic [63:0] a   [7];
    logic [63:0] b   [7];
    logic [63:0] exp [7];
    logic        ill [7];
    op[0] = 4'b0111; a[0] = 64'hFFFF_FFFF_FFFF_FFFF; b[0] = 64'd1; exp[0] = 64'd1; ill[0] = 1'b0;
    op[1] = 4'b0101; a[1] = 64'h8000_0000_0000_0000; b[1] = 64'd4; exp[1] = 64'hF800_0000_0000_0000; ill[1] = 1'b0;
    op[2] = 4'b0011; a[2] = 64'd1; b[2] = 64'd65; exp[2] = 64'd2; ill[2] = 1'b0;
    op[3] = 4'b1111; a[3] = 64'd9; b[3] = 64'd3; exp[3] = 64'd0; ill[3] = 1'b1;
    op[4] = 4'b0100; a[4] = 64'h8000_0000_0000_0000; b[4] = 64'd4; exp[4] = 64'h0800_0000_0000_0000; ill[4] = 1'b0;
    op[5] = 4'b1100; a[5] = 64'd0; b[5] = 64'h0000_0000_0000_00FF; exp[5] = 64'hFFFF_FFFF_FFFF_FF00; ill[5] = 1'b0;
    op[6] = 4'b0111; a[6] = 64'd1; b[6] = 64'hFFFF_FFFF_FFFF_FFFF; exp[6] = 64'd0; ill[6] = 1'b0;
    drain();
    for (int i = 0; i < 7; i++) begin
      issue(op[i], a[i], b[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== exp[i] || illegal !== ill[i] || zero !== (exp[i] == 64'd0)) begin
        n_err++;
        $display("[TB] FAIL op_%0d ctrl=%b: got valid=%b result=%h illegal=%b zero=%b, expected 1/%h/%b/%b",
                 i, op[i], out_valid, result, illegal, zero, exp[i], ill[i], (exp[i] == 64'd0));
      end
    end
  endtask

  task automatic test_mul();
    int   cyc;
    logic ready_seen;
    drain();
`ifdef ALU_MUL_EN
    issue(4'b1000, 64'd7, 64'd6);
    cyc = 1;
    ready_seen = 1'b0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 65) begin
      n_err++;
      $display("[TB] FAIL mul_latency: got %0d cycles, expected 65", cyc);
    end
    n_cmp++;
    if (ready_seen !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mul_in_ready_busy: got in_ready high during BUSY, expected 0");
    end
    n_cmp++;
    if (result !== 64'd42 || zero !== 1'b0 || illegal !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mul_7x6: got result=%0d zero=%b illegal=%b, expected 42/0/0", result, zero, illegal);
    end
    issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 65 || result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++;
      $display("[TB] FAIL mul_wrap: got cycles=%0d result=%h, expected 65/fffffffffffffffd", cyc, result);
    end
`else
    issue(4'b1000, 64'd7, 64'd6);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd0 || illegal !== 1'b1 || zero !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mul_disabled: got valid=%b result=%0d illegal=%b zero=%b, expected 1/0/1/1",
               out_valid, result, illegal, zero);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic held_ok;
    drain();
    out_ready = 1'b0;
    issue(4'b0000, 64'hF0, 64'h3C);
    // A second op is presented while the result is blocked; it must wait.
    control = 4'b0001; number1 = 64'd1; number2 = 64'd2; in_valid = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== 64'h30 || in_ready !== 1'b0 || zero !== 1'b0) held_ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (held_ok !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL backpressure_hold: got valid=%b result=%h in_ready=%b, expected 1/30/0 over 5 cycles",
               out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL backpressure_ready: got in_ready=%b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd3) begin
      n_err++;
      $display("[TB] FAIL backpressure_next: got valid=%b result=%0d, expected 1/3", out_valid, result);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL backpressure_consumed: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    logic stray;
    drain();
`ifdef ALU_MUL_EN
    issue(4'b0010, 64'd4, 64'd4);
    issue(4'b1000, 64'd7, 64'd6);
`else
    out_ready = 1'b0;
    issue(4'b0010, 64'd4, 64'd4);
`endif
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 64'd0 || zero !== 1'b0 || illegal !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_op: got valid=%b in_ready=%b result=%0d zero=%b illegal=%b, expected all 0",
               out_valid, in_ready, result, zero, illegal);
    end
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    stray = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_no_stray: got out_valid high after reset, expected 0");
    end
    issue(4'b0010, 64'd1, 64'd2);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 64'd3) begin
      n_err++;
      $display("[TB] FAIL reset_then_add: got valid=%b result=%0d, expected 1/3", out_valid, result);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    $display("[TB] alu_seq directed bench start");
    test_reset();
    test_sub_add();
    test_back_to_back();
    test_ops();
    test_mul();
    test_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor of the combinational 64-bit ALU, for the RISC-V execute stage.
- Accepts one operation per handshake on a valid/ready input channel and returns the result on a valid/ready output channel.
- Single-cycle ops complete with 1-cycle latency.
- Multiply runs on an iterative shift-add unit over multiple cycles.
- Adds shifts, SLT, backpressure and an illegal-op flag.

Parameters:
WIDTH, 64, operand/result width in bits; legal range 8..64, power of two.
SHW, $clog2(WIDTH), shift-amount bits taken from number2 (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept an operation.
number1  input  WIDTH  operand A.
number2  input  WIDTH  operand B.
control  input  4  opcode.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
result  output  WIDTH  registered result.
zero  output  1  result == 0, registered with result.
illegal  output  1  control not a supported opcode, registered with result.

Behaviour:
- Reset: all outputs and state go to 0 immediately on reset and stay there while reset is high.
  - result=0, zero=0, illegal=0, out_valid=0, FSM=IDLE.
  - in_ready=0 during reset and 1 in the first cycle after release.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1/0); 1100 NOR.
  - 0011 SLL; 0100 SRL; 0101 SRA, with shift amount = number2[SHW-1:0].
  - 1000 MUL, low WIDTH bits of the product.
  - All other codes are illegal.
- Arithmetic is modulo 2^WIDTH. There is no overflow/carry output.
- Accept = in_valid & in_ready. Operands and opcode are captured only on accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back issue.
- FSM:
  - IDLE: on accept of a non-MUL op → DONE, with result/zero/illegal loaded at that edge. On accept of MUL → BUSY.
  - BUSY: iterative multiplier runs exactly WIDTH cycles, one multiplier bit per cycle, LSB first. On the final iteration → DONE, result loaded.
  - DONE: out_valid=1. result, zero and illegal are held stable until out_ready.
    - out_ready & accept: same transitions as IDLE, new result replaces old; out_valid stays 1 for a non-MUL op.
    - out_ready & !accept: → IDLE.
- Latency from accept edge to out_valid: 1 cycle for non-MUL ops, WIDTH+1 cycles for MUL.
- Illegal op: result=0, zero=1, illegal=1, 1-cycle latency; the op still completes the handshake.
- While in_valid=0, in_valid held with in_ready=0 has no effect.
- Reset asserted mid-MUL aborts the operation. No result is emitted after reset release.
- out_valid is never asserted in the same cycle as reset or in the cycle it releases.

Optional Feature:
ALU_MUL_EN
- Defined: iterative multiplier present, and 1000 performs MUL as above.
- Undefined: multiplier is not instantiated and BUSY is unreachable. 1000 is treated as illegal (illegal=1, result=0, 1-cycle latency).

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL);
  - FSM state encoding (IDLE, BUSY, DONE).
- One sub-module: alu_mul_iter, WIDTH-parametrised shift-add multiplier.
  - Interface: start, a, b, busy, done, product_lo.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- WIDTH=64, number1=30, number2=20, control=0110, in_valid for 1 cycle, out_ready=1 → next cycle out_valid=1, result=10, zero=0. Then control=0010 with 20/30 → result=50.
- Back-to-back: ADD 5+5 then SUB 7-7 on consecutive cycles with out_ready=1 → results 10 then 0 (zero=1) on consecutive cycles; in_ready stays 1.
- MUL 7×6 (ALU_MUL_EN defined) → out_valid exactly 65 cycles after accept, result=42, in_ready=0 throughout BUSY. Without the macro → illegal=1, result=0 after 1 cycle.
- SLT number1=-1, number2=1 → 1. SRA 0x8000_0000_0000_0000 by 4 → 0xF800_0000_0000_0000. SLL by number2=65 → shift of 1. control=1111 → illegal=1, zero=1.
- Backpressure: out_ready=0 for 5 cycles after a result → result/out_valid held stable, in_ready=0. Result is consumed on the first out_ready=1.
- Reset asserted at cycle 10 of a MUL → outputs 0 immediately. After release: in_ready=1, out_valid stays 0 with no new input, and a subsequent ADD 1+2 → 3.
